// File: rtl/t2s_pass_sequencer_pkg.sv
// Shared types and helpers for the SAUS pass sequencer.
// Lane count is fixed at 32. The group-interleave destination rule lives here
// so the RTL permutation network and any other users agree on one definition.
package t2s_seq_pkg;

  localparam int LANES  = 32;
  localparam int COEF_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [LANES-1:0]        coef_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Active size log2 is limited to 2..5 (4..32 lanes).
  function automatic logic [2:0] clamp_log2size(input logic [2:0] l2);
    if (l2 < 3'd2) return 3'd2;
    if (l2 > 3'd5) return 3'd5;
    return l2;
  endfunction

  // Destination lane of 'pos' for one interleave pass with group size nk.
  // The first half of a group lands on lanes 0,1 mod 4; the second half is
  // folded back onto lanes 2,3 mod 4 in reverse pair order.
  function automatic logic [4:0] perm_dst(input logic [4:0] pos, input logic [5:0] nk);
    int unsigned r;
    int unsigned p;
    int unsigned half;
    int unsigned base;
    int unsigned dst;
    r    = 32'(pos) & (32'(nk) - 32'd1);
    p    = r & 32'd1;
    half = 32'(nk) >> 1;
    base = 32'(pos) - r;
    if (r < half) dst = base + 32'd2 * r - p;
    else          dst = base + 32'(nk) - 32'd1 - 32'd2 * (r - p - half) - (32'd1 - p);
    return dst[4:0];
  endfunction

endpackage

// File: rtl/t2s_pass_sequencer_if.sv
// Requester/result bus of the pass sequencer. The sequencer uses the slave
// modport; the front-ends plus downstream consumer use the master side.
interface t2s_pass_sequencer_if
  import t2s_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]                        req_valid;
  logic [NREQ-1:0]                        req_ready;
  logic [NREQ-1:0][LANES-1:0][WIDTH-1:0]  req_vec;
  logic [NREQ-1:0][2:0]                   req_log2size;
  logic [NREQ-1:0][2:0]                   req_stages;
  logic                                   out_valid;
  logic                                   out_ready;
  logic [LANES-1:0][WIDTH-1:0]            out_vec;
  logic [IDW-1:0]                         out_src;
  logic                                   busy;

  modport master (
    output req_valid, req_vec, req_log2size, req_stages, out_ready,
    input  req_ready, out_valid, out_vec, out_src, busy
  );

  modport slave (
    input  req_valid, req_vec, req_log2size, req_stages, out_ready,
    output req_ready, out_valid, out_vec, out_src, busy
  );

endinterface

// File: rtl/t2s_pass_sequencer_perm_pass.sv
// One combinational group-interleave pass over a 32-lane vector.
// Lanes at or above the active size pass straight through.
module t2s_perm_pass
  import t2s_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [LANES-1:0][WIDTH-1:0] i_vec,
  input  logic [5:0]                  i_nk,
  input  logic [5:0]                  i_sz,
  output logic [LANES-1:0][WIDTH-1:0] o_vec
);

  // Scatter each active lane to its destination; the mapping is a bijection
  // within each group, so every active lane is written exactly once.
  always_comb begin
    o_vec = i_vec;
    for (int unsigned pos = 0; pos < LANES; pos++) begin
      if (pos < 32'(i_sz)) o_vec[perm_dst(5'(pos), i_nk)] = i_vec[pos];
    end
  end

endmodule

// File: rtl/t2s_pass_sequencer.sv
// Round-robin shared SAUS reorder stage: accepts one job at a time, applies
// S interleave passes (one per cycle) and returns the result with source id.
// Optional statistics counters are enabled by defining T2S_SEQ_STATS_EN.
module t2s_pass_sequencer
  import t2s_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  t2s_pass_sequencer_if.slave  bus
`ifdef T2S_SEQ_STATS_EN
  ,
  output logic [NREQ-1:0][15:0] stat_jobs,
  output logic [15:0]           stat_stall
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e                      r_state;
  logic [LANES-1:0][WIDTH-1:0] r_work;
  logic [5:0]                  r_sz;
  logic [2:0]                  r_s;
  logic [2:0]                  r_k;
  logic [IDW-1:0]              r_id;
  logic [IDW-1:0]              r_rr;
  logic                        r_out_valid;
  logic                        r_busy;

  logic [NREQ-1:0]             w_ready;
  logic                        w_any;
  logic [IDW-1:0]              w_gidx;
  logic                        w_accept;
  logic [2:0]                  w_l2;
  logic [2:0]                  w_smax;
  logic [2:0]                  w_stages;
  logic [2:0]                  w_s;
  logic [IDW-1:0]              w_rr_next;
  logic [5:0]                  w_nk;
  logic [LANES-1:0][WIDTH-1:0] w_pass;

  // Round-robin pick of the first valid requester at/after the pointer.
  always_comb begin
    w_ready = '0;
    w_any   = 1'b0;
    w_gidx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && bus.req_valid[(32'(r_rr) + i) % NREQ]) begin
        w_any  = 1'b1;
        w_gidx = IDW'((32'(r_rr) + i) % NREQ);
      end
    end
    if (w_any && (r_state == ST_IDLE) && !rst) w_ready[w_gidx] = 1'b1;
  end

  assign w_accept  = |(w_ready & bus.req_valid);
  assign w_l2      = clamp_log2size(bus.req_log2size[w_gidx]);
  assign w_smax    = w_l2 - 3'd1;
  assign w_stages  = bus.req_stages[w_gidx];
  assign w_s       = (w_stages > w_smax) ? w_smax : w_stages;
  assign w_rr_next = IDW'((32'(w_gidx) + 32'd1) % NREQ);
  assign w_nk      = r_sz >> r_k;

  t2s_perm_pass #(.WIDTH(WIDTH)) u_pass (
    .i_vec (r_work),
    .i_nk  (w_nk),
    .i_sz  (r_sz),
    .o_vec (w_pass)
  );

  // Job FSM: capture on accept, one pass per RUN cycle, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_sz        <= '0;
      r_s         <= '0;
      r_k         <= '0;
      r_id        <= '0;
      r_rr        <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work <= bus.req_vec[w_gidx];
            r_sz   <= 6'd1 << w_l2;
            r_s    <= w_s;
            r_k    <= '0;
            r_id   <= w_gidx;
            r_rr   <= w_rr_next;
            r_busy <= 1'b1;
            if (w_s == 3'd0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          r_work <= w_pass;
          r_k    <= r_k + 3'd1;
          if (r_k == r_s - 3'd1) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_vec   = r_work;
  assign bus.out_src   = r_id;
  assign bus.busy      = r_busy;

`ifdef T2S_SEQ_STATS_EN
  logic [NREQ-1:0][15:0] r_stat_jobs;
  logic [15:0]           r_stat_stall;

  // Saturating per-requester accept counts and DONE back-pressure cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_jobs  <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_accept && (r_stat_jobs[w_gidx] != '1))
        r_stat_jobs[w_gidx] <= r_stat_jobs[w_gidx] + 16'd1;
      if ((r_state == ST_DONE) && !bus.out_ready && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_jobs  = r_stat_jobs;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_t2s_pass_sequencer.sv
// Bench for t2s_pass_sequencer: directed scenarios followed by random jobs,
// checked against a lane-array model of the interleave rule, round-robin
// arbitration and latency. Stats ports are checked when T2S_SEQ_STATS_EN is set.
module tb_t2s_pass_sequencer;
  import t2s_seq_pkg::*;

  localparam int W  = 16;
  localparam int NR = 2;
  localparam int VB = LANES * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t2s_pass_sequencer_if #(.WIDTH(W), .NREQ(NR)) bus ();

`ifdef T2S_SEQ_STATS_EN
  logic [NR-1:0][15:0] stat_jobs;
  logic [15:0]         stat_stall;
`endif

  t2s_pass_sequencer #(.WIDTH(W), .NREQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef T2S_SEQ_STATS_EN
    ,
    .stat_jobs  (stat_jobs),
    .stat_stall (stat_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int rr_m     = 0;
  int stall_m  = 0;
  int jobs_m [NR];

  logic [VB-1:0] tv  [NR];
  logic [2:0]    tl2 [NR];
  logic [2:0]    tst [NR];

  task automatic chk(input string tag, input logic [VB-1:0] obs, input logic [VB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp_l2(input int l2);
    return (l2 < 2) ? 2 : ((l2 > 5) ? 5 : l2);
  endfunction

  function automatic int model_s(input int l2, input int st);
    int c;
    c = clamp_l2(l2);
    return (st < c - 1) ? st : c - 1;
  endfunction

  // Apply the interleave rule literally on an integer lane array.
  function automatic logic [VB-1:0] model_out(input logic [VB-1:0] v, input int l2, input int st);
    int a [LANES];
    int b [LANES];
    int sz, s, nk, r, p, base, dst;
    logic [VB-1:0] res;
    sz = 1 << clamp_l2(l2);
    s  = model_s(l2, st);
    for (int i = 0; i < LANES; i++) a[i] = int'(v[i*W +: W]);
    for (int k = 0; k < s; k++) begin
      nk = sz >> k;
      b  = a;
      for (int pos = 0; pos < sz; pos++) begin
        r    = pos % nk;
        p    = r % 2;
        base = pos - r;
        if (r < nk / 2) dst = base + 2 * r - p;
        else            dst = base + nk - 1 - 2 * (r - p - nk / 2) - (1 - p);
        b[dst] = a[pos];
      end
      a = b;
    end
    for (int i = 0; i < LANES; i++) res[i*W +: W] = W'(a[i]);
    return res;
  endfunction

  function automatic int model_grant(input logic [NR-1:0] vm);
    for (int i = 0; i < NR; i++)
      if (vm[(rr_m + i) % NR]) return (rr_m + i) % NR;
    return 0;
  endfunction

  task automatic drive(input logic [NR-1:0] vm);
    bus.req_valid = vm;
    for (int r = 0; r < NR; r++) begin
      bus.req_vec[r]      = tv[r];
      bus.req_log2size[r] = tl2[r];
      bus.req_stages[r]   = tst[r];
    end
  endtask

  task automatic run_job(input logic [NR-1:0] vm, input int stall);
    int g, s, lat;
    logic [VB-1:0] exp;
    logic [NR-1:0] oh;
    bus.out_ready = 1'b0;
    drive(vm);
    #1;
    g     = model_grant(vm);
    oh    = '0;
    oh[g] = 1'b1;
    chk("grant", bus.req_ready, oh);
    exp = model_out(tv[g], int'(tl2[g]), int'(tst[g]));
    s   = model_s(int'(tl2[g]), int'(tst[g]));
    step();
    rr_m = (g + 1) % NR;
    jobs_m[g]++;
    chk("busy_after_accept", bus.busy, 1);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      chk("ready_while_busy", bus.req_ready, 0);
      step();
      lat++;
    end
    chk("latency", lat, s + 1);
    chk("out_vec", bus.out_vec, exp);
    chk("out_src", bus.out_src, g);
    for (int i = 0; i < stall; i++) begin
      chk("ready_in_done", bus.req_ready, 0);
      step();
      stall_m++;
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_vec", bus.out_vec, exp);
      chk("hold_src", bus.out_src, g);
    end
`ifdef T2S_SEQ_STATS_EN
    chk("stat_jobs", stat_jobs[g], jobs_m[g]);
    chk("stat_stall", stat_stall, stall_m);
`endif
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    step();
    chk("valid_after_handshake", bus.out_valid, 0);
    chk("busy_after_handshake", bus.busy, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      jobs_m[r] = 0;
      for (int i = 0; i < LANES; i++) tv[r][i*W +: W] = W'(i);
      tl2[r] = 3'd5;
      tst[r] = 3'd1;
    end
    bus.out_ready = 1'b0;
    drive('1);

    // Reset state, with requests pending so ready gating is exercised.
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_vec", bus.out_vec, 0);
    chk("rst_out_src", bus.out_src, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    bus.req_valid = '0;

    // Single job, full size, one pass, ramp input.
    run_job(2'b01, 0);

    // Size 8, two passes; lanes 8..31 untouched.
    tl2[0] = 3'd3;
    tst[0] = 3'd2;
    run_job(2'b01, 0);

    // Both requesters valid, no passes: grants alternate, latency 1.
    for (int r = 0; r < NR; r++) begin
      tst[r] = 3'd0;
      tl2[r] = 3'($urandom_range(0, 7));
      for (int i = 0; i < LANES; i++) tv[r][i*W +: W] = W'($urandom);
    end
    for (int j = 0; j < 4; j++) run_job(2'b11, 0);

    // Back-pressure for 5 cycles in DONE.
    tl2[0] = 3'd4;
    tst[0] = 3'd2;
    run_job(2'b01, 5);

    // Reset during pass 1 of a three-pass job.
    tl2[0] = 3'd5;
    tst[0] = 3'd3;
    drive(2'b01);
    #1;
    chk("t5_grant", bus.req_ready, 2'b01);
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_m    = 0;
    stall_m = 0;
    for (int r = 0; r < NR; r++) jobs_m[r] = 0;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_out_vec", bus.out_vec, 0);
    chk("t5_out_src", bus.out_src, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_output", bus.out_valid, 0);
    end
    tst[0] = 3'd1;
    tst[1] = 3'd1;
    run_job(2'b11, 0);

    // Out-of-range size and stage count clamp to SZ=32, S=4.
    tl2[1] = 3'd7;
    tst[1] = 3'd7;
    run_job(2'b10, 1);

    // Random jobs.
    for (int j = 0; j < 40; j++) begin
      for (int r = 0; r < NR; r++) begin
        tl2[r] = 3'($urandom_range(0, 7));
        tst[r] = 3'($urandom_range(0, 7));
        for (int i = 0; i < LANES; i++) tv[r][i*W +: W] = W'($urandom);
      end
      run_job(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
